// File: rtl/inst_rom_loader_pkg.sv
// Shared definitions for the instruction ROM loader: memory geometry, bus
// widths, loader state codes and the image byte-order helper.
package inst_rom_loader_pkg;

   // Instruction memory depth in 16-bit words (power of two, <= 65536)
   localparam int ROM_DEPTH = 256;
   // Fetch address and instruction data widths
   localparam int ADDR_W    = 16;
   localparam int DATA_W    = 16;

   // Loader state encodings (3-bit, legacy-compatible values)
   localparam logic [2:0] LD_HDR_LO = 3'd0;
   localparam logic [2:0] LD_HDR_HI = 3'd1;
   localparam logic [2:0] LD_W_LO   = 3'd2;
   localparam logic [2:0] LD_W_HI   = 3'd3;
   localparam logic [2:0] LD_CHK    = 3'd4;
   localparam logic [2:0] LD_DONE   = 3'd5;
   localparam logic [2:0] LD_ERROR  = 3'd6;

   // Image words arrive little-endian: low byte first, high byte second
   function automatic logic [15:0] pack_le(input logic [7:0] lo, input logic [7:0] hi);
      return {hi, lo};
   endfunction

endpackage

// File: rtl/inst_rom_mem.sv
// DEPTH x 16 instruction array: one synchronous write port, one
// asynchronous read port (maps to distributed RAM). Contents not reset.
module inst_rom_mem #(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [15:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [15:0]   rdata
);

   logic [15:0] mem [DEPTH];

   // Synchronous write port
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Asynchronous read port
   always_comb begin
      rdata = mem[raddr];
   end

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction ROM with boot loader: fills the memory from a little-endian
// byte stream (CNT_LO, CNT_HI, CNT words LO/HI) and holds the CPU in reset
// until the image is complete. Reads at or beyond the loaded word count
// return 16'h0000.
// Optional: define INST_ROM_CHECKSUM_EN to require a trailing XOR checksum
// byte covering every preceding image byte.
module inst_rom_loader
   import inst_rom_loader_pkg::*;
#(
   parameter int DEPTH = ROM_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   input  logic              reload,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic [DATA_W-1:0] inst_data,
   output logic              cpu_rst_n,
   output logic              load_done,
   output logic              load_err
);

   localparam logic [16:0] DEPTH17 = 17'(DEPTH);

   logic [2:0]  state, state_nxt;
   logic [15:0] cnt;
   logic [15:0] cnt_full;
   logic [7:0]  lo_buf;
   logic [AW:0] wr_addr;
   logic [16:0] nxt_ext;
   logic [15:0] word_cnt;
   logic        accept;
   logic        we;
   logic        restart;
   logic [15:0] rd_word;
   logic        sum_ok;
   logic [2:0]  last_dst;

`ifdef INST_ROM_CHECKSUM_EN
   logic [7:0]  acc;
   assign sum_ok   = (rx_data == acc);
   assign last_dst = LD_CHK;
`else
   assign sum_ok   = 1'b1;
   assign last_dst = LD_DONE;
`endif

   assign rx_ready  = (state != LD_DONE) && (state != LD_ERROR);
   assign load_done = (state == LD_DONE);
   assign load_err  = (state == LD_ERROR);
   assign accept    = rx_valid && rx_ready;
   assign restart   = reload && ((state == LD_DONE) || (state == LD_ERROR));
   // The count high byte is still on rx_data while in HDR_HI
   assign cnt_full  = (state == LD_HDR_HI) ? {rx_data, cnt[7:0]} : cnt;
   assign nxt_ext   = 17'(wr_addr) + 17'd1;

   // Next-state and write-enable decode
   always_comb begin
      state_nxt = state;
      we        = 1'b0;
      case (state)
         LD_HDR_LO: if (accept) state_nxt = LD_HDR_HI;
         LD_HDR_HI: begin
            if (accept) begin
               if (cnt_full == 16'd0)                state_nxt = last_dst;
               else if ({1'b0, cnt_full} > DEPTH17)  state_nxt = LD_ERROR;
               else                                  state_nxt = LD_W_LO;
            end
         end
         LD_W_LO:   if (accept) state_nxt = LD_W_HI;
         LD_W_HI: begin
            if (accept) begin
               we = 1'b1;
               if (nxt_ext == {1'b0, cnt}) state_nxt = last_dst;
               else                        state_nxt = LD_W_LO;
            end
         end
         LD_CHK:    if (accept) state_nxt = sum_ok ? LD_DONE : LD_ERROR;
         LD_DONE,
         LD_ERROR:  if (reload) state_nxt = LD_HDR_LO;
         default:   state_nxt = LD_HDR_LO;
      endcase
   end

   // Loader state, header/word capture, published word count and CPU reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= LD_HDR_LO;
         cnt       <= '0;
         lo_buf    <= '0;
         wr_addr   <= '0;
         word_cnt  <= '0;
         cpu_rst_n <= 1'b0;
      end else begin
         state     <= state_nxt;
         // Drops together with the reload that leaves DONE
         cpu_rst_n <= (state == LD_DONE) && !reload;
         if (accept) begin
            case (state)
               LD_HDR_LO: cnt[7:0]  <= rx_data;
               LD_HDR_HI: cnt[15:8] <= rx_data;
               LD_W_LO:   lo_buf    <= rx_data;
               LD_W_HI:   wr_addr   <= wr_addr + 1'b1;
               default: ;
            endcase
         end
         if ((state_nxt == LD_DONE) && (state != LD_DONE)) word_cnt <= cnt_full;
         if (restart) begin
            word_cnt <= '0;
            wr_addr  <= '0;
         end
      end
   end

`ifdef INST_ROM_CHECKSUM_EN
   // XOR checksum over every image byte ahead of the check byte
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           acc <= '0;
      else if (restart)                     acc <= '0;
      else if (accept && state != LD_CHK)   acc <= acc ^ rx_data;
   end
`endif

   inst_rom_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (we),
      .waddr (wr_addr[AW-1:0]),
      .wdata (pack_le(lo_buf, rx_data)),
      .raddr (inst_addr[AW-1:0]),
      .rdata (rd_word)
   );

   // Reads beyond the published image return zero (halts fetch)
   always_comb begin
      inst_data = (inst_addr < word_cnt) ? rd_word : '0;
   end

endmodule

// File: tb/tb_inst_rom_loader.sv
// Self-checking bench for inst_rom_loader. Honours INST_ROM_CHECKSUM_EN.
module tb_inst_rom_loader;

   localparam int DEPTH = inst_rom_loader_pkg::ROM_DEPTH;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic        reload = 1'b0;
   logic [15:0] inst_addr = '0;
   logic [15:0] inst_data;
   logic        cpu_rst_n;
   logic        load_done;
   logic        load_err;

   int checks = 0;
   int failures = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   inst_rom_loader dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .reload    (reload),
      .inst_addr (inst_addr),
      .inst_data (inst_data),
      .cpu_rst_n (cpu_rst_n),
      .load_done (load_done),
      .load_err  (load_err)
   );

   // ---------------- image-level model ----------------
   logic [7:0]  q[$];
   logic [15:0] model_mem [DEPTH];
   int          m_wcnt = 0;
   bit          m_cpu = 1'b0;

`ifdef INST_ROM_CHECKSUM_EN
   localparam int EXTRA = 1;
`else
   localparam int EXTRA = 0;
`endif

   function automatic int m_cnt();
      return int'(q[0]) + 256 * int'(q[1]);
   endfunction

   function automatic bit m_sum_ok(int need);
      logic [7:0] x;
      if (EXTRA == 0) return 1'b1;
      x = '0;
      for (int i = 0; i < need - 1; i++) x ^= q[i];
      return x == q[need-1];
   endfunction

   function automatic bit m_done();
      int need;
      if (q.size() < 2) return 1'b0;
      if (m_cnt() > DEPTH) return 1'b0;
      need = 2 + 2 * m_cnt() + EXTRA;
      return (q.size() == need) && m_sum_ok(need);
   endfunction

   function automatic bit m_err();
      int need;
      if (q.size() < 2) return 1'b0;
      if (m_cnt() > DEPTH) return 1'b1;
      need = 2 + 2 * m_cnt() + EXTRA;
      return (q.size() == need) && !m_sum_ok(need);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_wcnt = 0;
         m_cpu  = 1'b0;
      end else begin
         bit d0;
         d0 = m_done();
         if (reload && (m_done() || m_err())) begin
            q.delete();
            m_wcnt = 0;
         end else if (rx_valid && !m_done() && !m_err()) begin
            q.push_back(rx_data);
            if (m_done()) begin
               for (int i = 0; i < m_cnt(); i++)
                  model_mem[i] = {q[3+2*i], q[2+2*i]};
               m_wcnt = m_cnt();
            end
         end
         m_cpu = d0 && m_done();
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (cmp_en) begin
         int exp_data;
         exp_data = (int'(inst_addr) < m_wcnt) ? int'(model_mem[inst_addr]) : 0;
         chk("m_rx_ready",  int'(rx_ready),  int'(!m_done() && !m_err()));
         chk("m_load_done", int'(load_done), int'(m_done()));
         chk("m_load_err",  int'(load_err),  int'(m_err()));
         chk("m_cpu_rst_n", int'(cpu_rst_n), int'(m_cpu));
         chk("m_inst_data", int'(inst_data), exp_data);
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk); #2;
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   task automatic pulse_reload();
      reload = 1'b1;
      @(posedge clk); #2;
      reload = 1'b0;
   endtask

   task automatic rd(input string name, input logic [15:0] a, input int exp);
      inst_addr = a;
      #1;
      chk(name, int'(inst_data), exp);
   endtask

   initial begin
      logic [15:0] big;
      big = 16'(DEPTH + 1);
      rst_n = 1'b0;
      idle(3);
      cmp_en = 1'b1;
      chk("rst_rx_ready", int'(rx_ready), 1);
      chk("rst_cpu_rst_n", int'(cpu_rst_n), 0);
      chk("rst_load_done", int'(load_done), 0);
      rst_n = 1'b1;
      idle(1);

      // Image of three words
      send(8'h03); send(8'h00);
      send(8'h34); send(8'h12);
      send(8'hCD); send(8'hAB);
      send(8'h01); send(8'h00);
`ifdef INST_ROM_CHECKSUM_EN
      chk("t1_pre_chk_ready", int'(rx_ready), 1);
      send(8'h42);
`endif
      chk("t1_rx_ready_drop", int'(rx_ready), 0);
      chk("t1_done", int'(load_done), 1);
      chk("t1_cpu_still_rst", int'(cpu_rst_n), 0);
      idle(1);
      chk("t1_cpu_release", int'(cpu_rst_n), 1);
      rd("t1_rd0", 16'd0, 16'h1234);
      rd("t1_rd1", 16'd1, 16'hABCD);
      rd("t1_rd2", 16'd2, 16'h0001);
      rd("t1_rd3", 16'd3, 16'h0000);
      idle(1);

      // Oversized count -> error, then reload
      pulse_reload();
      chk("t2_reload_cpu", int'(cpu_rst_n), 0);
      rd("t2_rd0_after_reload", 16'd0, 16'h0000);
      send(big[7:0]); send(big[15:8]);
      chk("t2_err", int'(load_err), 1);
      chk("t2_err_cpu", int'(cpu_rst_n), 0);
      chk("t2_err_ready", int'(rx_ready), 0);
      idle(2);
      pulse_reload();
      chk("t2_reload_err", int'(load_err), 0);
      chk("t2_reload_ready", int'(rx_ready), 1);

      // Zero-length image
      send(8'h00); send(8'h00);
`ifdef INST_ROM_CHECKSUM_EN
      send(8'h00);
`endif
      chk("t3_done", int'(load_done), 1);
      rd("t3_rd0", 16'd0, 16'h0000);
      rd("t3_rd_max", 16'hFFFF, 16'h0000);
      idle(2);
      pulse_reload();

      // Gap between LO and HI bytes of word 1
      send(8'h02); send(8'h00);
      send(8'h11); send(8'h22);
      send(8'h44);
      idle(5);
      chk("t4_gap_not_done", int'(load_done), 0);
      send(8'h33);
`ifdef INST_ROM_CHECKSUM_EN
      send(8'h46);
`endif
      chk("t4_done", int'(load_done), 1);
      rd("t4_rd0", 16'd0, 16'h2211);
      rd("t4_rd1", 16'd1, 16'h3344);
      rd("t4_rd2", 16'd2, 16'h0000);
      idle(2);
      pulse_reload();

      // Asynchronous reset mid-load
      send(8'h01); send(8'h00); send(8'hAA); send(8'hBB);
      rst_n = 1'b0;
      #1;
      chk("t5_arst_ready", int'(rx_ready), 1);
      chk("t5_arst_done", int'(load_done), 0);
      chk("t5_arst_cpu", int'(cpu_rst_n), 0);
      idle(2);
      rst_n = 1'b1;
      idle(1);
      send(8'h01); send(8'h00); send(8'hFF); send(8'h00);
`ifdef INST_ROM_CHECKSUM_EN
      send(8'hFE);
`endif
      chk("t5_done", int'(load_done), 1);
      rd("t5_rd0", 16'd0, 16'h00FF);
      rd("t5_rd1", 16'd1, 16'h0000);
      idle(2);

`ifdef INST_ROM_CHECKSUM_EN
      // Checksum good and bad
      pulse_reload();
      send(8'h01); send(8'h00); send(8'h3C); send(8'h5A); send(8'h67);
      chk("t6_chk_good", int'(load_done), 1);
      rd("t6_rd0", 16'd0, 16'h5A3C);
      idle(2);
      pulse_reload();
      send(8'h01); send(8'h00); send(8'h3C); send(8'h5A); send(8'h68);
      chk("t6_chk_bad", int'(load_err), 1);
      rd("t6_rd0_bad", 16'd0, 16'h0000);
      idle(2);
`endif

      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
